// File: rtl/b10_half_adder_pkg.sv
// Shared constants and helpers for the packed-BCD half adder / incrementer.
// Digit width and the decimal limits used by every digit cell.
package b10_half_adder_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Digits 10..15 are not legal BCD; the cell flags them but still behaves deterministically.
  function automatic logic bcd_is_bad(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX);
  endfunction

  // A digit at or above 9 rolls over when incremented.
  function automatic logic bcd_at_top(input logic [BCD_W-1:0] d);
    return (d >= BCD_MAX);
  endfunction

endpackage

// File: rtl/b10_digit_inc.sv
// One BCD digit incrementer cell: passes x through, adds ci, or wraps to zero with carry.
// Illegal digits (10..15) are treated like 9 so they never produce out-of-range sums.
module b10_digit_inc
  import b10_half_adder_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co,
  output logic             bad
);

  logic at_top;

  assign at_top = bcd_at_top(x);
  assign co     = ci & at_top;
  assign bad    = bcd_is_bad(x);

  always_comb begin
    s = x;
    if (ci) begin
      s = at_top ? BCD_ZERO : (x + 4'd1);
    end
  end

endmodule

// File: rtl/b10_half_adder.sv
// Packed-BCD half adder: adds a single carry-in to DIGITS rippled decimal digits.
// Outputs are combinational by default, or registered with an async active-low reset.
module b10_half_adder
  import b10_half_adder_pkg::*;
#(
  parameter int DIGITS     = 1,
  parameter bit REGISTERED = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset_,
  input  logic [BCD_W*DIGITS-1:0]   x3_x0,
  input  logic                      cin,
  output logic [BCD_W*DIGITS-1:0]   s3_s0,
  output logic                      cout,
  output logic                      err
);

  logic [DIGITS:0]               carry;
  logic [DIGITS-1:0]             bad;
  logic [BCD_W*DIGITS-1:0]       sum_next;
  logic                          cout_next;
  logic                          err_next;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      b10_digit_inc u_digit (
        .x   (x3_x0[gi*BCD_W +: BCD_W]),
        .ci  (carry[gi]),
        .s   (sum_next[gi*BCD_W +: BCD_W]),
        .co  (carry[gi+1]),
        .bad (bad[gi])
      );
    end
  endgenerate

  assign cout_next = carry[DIGITS];
  assign err_next  = |bad;

  generate
    if (REGISTERED) begin : g_reg
      logic [BCD_W*DIGITS-1:0] sum_reg;
      logic                    cout_reg;
      logic                    err_reg;

      always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
          sum_reg  <= '0;
          cout_reg <= 1'b0;
          err_reg  <= 1'b0;
        end else begin
          sum_reg  <= sum_next;
          cout_reg <= cout_next;
          err_reg  <= err_next;
        end
      end

      assign s3_s0 = sum_reg;
      assign cout  = cout_reg;
      assign err   = err_reg;
    end else begin : g_comb
      // Counter chains need cout in the same cycle, so nothing here may be clocked.
      logic unused_clock_reset;
      assign unused_clock_reset = clock ^ reset_;

      assign s3_s0 = sum_next;
      assign cout  = cout_next;
      assign err   = err_next;
    end
  endgenerate

endmodule

// File: tb/tb_b10_half_adder.sv
// Scoreboard bench: a driver queues expected results from a decimal-arithmetic model,
// a negedge monitor pops and compares them against three differently configured instances.
module tb_b10_half_adder;

  logic clock  = 1'b0;
  logic reset_ = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]  x1 = '0;  logic cin1 = 1'b0;  logic [3:0]  s1;  logic cout1, err1;
  logic [11:0] x3 = '0;  logic cin3 = 1'b0;  logic [11:0] s3;  logic cout3, err3;
  logic [7:0]  xr = '0;  logic cinr = 1'b0;  logic [7:0]  sr;  logic coutr, errr;

  b10_half_adder #(.DIGITS(1), .REGISTERED(1'b0)) u_d1 (
    .clock(clock), .reset_(reset_), .x3_x0(x1), .cin(cin1), .s3_s0(s1), .cout(cout1), .err(err1));
  b10_half_adder #(.DIGITS(3), .REGISTERED(1'b0)) u_d3 (
    .clock(clock), .reset_(reset_), .x3_x0(x3), .cin(cin3), .s3_s0(s3), .cout(cout3), .err(err3));
  b10_half_adder #(.DIGITS(2), .REGISTERED(1'b1)) u_reg (
    .clock(clock), .reset_(reset_), .x3_x0(xr), .cin(cinr), .s3_s0(sr), .cout(coutr), .err(errr));

  typedef struct {
    logic [11:0] x;
    logic        ci;
    logic [11:0] s;
    logic        co;
    logic        e;
    int          stamp;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t qr[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Valid operands use whole-number decimal arithmetic; illegal digits follow the wrap rules.
  function automatic void ref_model(input int nd, input logic [11:0] x, input logic ci,
                                    output logic [11:0] s, output logic co, output logic e);
    int   v, p, dig;
    logic c;
    s = '0; co = 1'b0; e = 1'b0; v = 0; p = 1;
    for (int i = 0; i < nd; i++) begin
      dig = int'(x[4*i +: 4]);
      if (dig > 9) e = 1'b1;
      v += dig * p;
      p *= 10;
    end
    if (!e) begin
      v += int'(ci);
      co = (v == p);
      v  = v % p;
      for (int i = 0; i < nd; i++) begin
        s[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end else begin
      c = ci;
      for (int i = 0; i < nd; i++) begin
        dig = int'(x[4*i +: 4]);
        if (c) begin
          s[4*i +: 4] = (dig >= 9) ? 4'd0 : 4'(dig + 1);
          c = (dig >= 9);
        end else begin
          s[4*i +: 4] = 4'(dig);
        end
      end
      co = c;
    end
  endfunction

  task automatic check(input string name, input logic [11:0] x, input logic ci,
                       input logic [11:0] got_s, input logic got_c, input logic got_e,
                       input logic [11:0] exp_s, input logic exp_c, input logic exp_e);
    n_vec++;
    if (got_s !== exp_s || got_c !== exp_c || got_e !== exp_e) begin
      n_bad++;
      $display("FAIL %s x=%h cin=%b: got s=%h cout=%b err=%b, expected s=%h cout=%b err=%b",
               name, x, ci, got_s, got_c, got_e, exp_s, exp_c, exp_e);
    end else begin
      $display("ok   %s x=%h cin=%b s=%h cout=%b err=%b", name, x, ci, got_s, got_c, got_e);
    end
  endtask

  function automatic logic [3:0] rand_digit();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 4) return 4'd9;
    if (r < 6) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 8));
  endfunction

  task automatic drive(input logic [3:0] a1, input logic c1, input logic [11:0] a3, input logic c3,
                       input logic [7:0] ar, input logic cr);
    exp_t e;
    @(posedge clock);
    #1;
    x1 = a1; cin1 = c1; x3 = a3; cin3 = c3; xr = ar; cinr = cr;
    e.stamp = cyc;
    e.x = {8'h0, a1}; e.ci = c1;
    ref_model(1, e.x, c1, e.s, e.co, e.e);
    q1.push_back(e);
    e.x = a3; e.ci = c3;
    ref_model(3, e.x, c3, e.s, e.co, e.e);
    q3.push_back(e);
    e.x = {4'h0, ar}; e.ci = cr;
    ref_model(2, e.x, cr, e.s, e.co, e.e);
    qr.push_back(e);
  endtask

  // Monitor: combinational results are due the negedge after issue, registered ones one cycle later.
  always @(negedge clock) begin
    if (q1.size() > 0) begin
      mon_e = q1.pop_front();
      check("d1", mon_e.x, mon_e.ci, {8'h0, s1}, cout1, err1, mon_e.s, mon_e.co, mon_e.e);
    end
    if (q3.size() > 0) begin
      mon_e = q3.pop_front();
      check("d3", mon_e.x, mon_e.ci, s3, cout3, err3, mon_e.s, mon_e.co, mon_e.e);
    end
    while (qr.size() > 0 && qr[0].stamp + 1 < cyc) begin
      mon_e = qr.pop_front();
      n_vec++; n_bad++;
      $display("FAIL reg_late x=%h: got no check at cycle %0d, required at cycle %0d",
               mon_e.x, cyc, mon_e.stamp + 1);
    end
    if (qr.size() > 0 && qr[0].stamp + 1 == cyc) begin
      mon_e = qr.pop_front();
      check("reg", mon_e.x, mon_e.ci, {4'h0, sr}, coutr, errr, mon_e.s, mon_e.co, mon_e.e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of run, required $finish before 1000000");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        ce;
    logic [3:0]  fb;
    logic [11:0] r3;
    #2;
    check("reset_state", {4'h0, xr}, cinr, {4'h0, sr}, coutr, errr, 12'h0, 1'b0, 1'b0);
    @(negedge clock);
    reset_ = 1'b1;

    // Exhaustive single-digit sweep including illegal codes.
    for (int x = 0; x < 16; x++) begin
      for (int c = 0; c < 2; c++) begin
        drive(4'(x), 1'(c), {rand_digit(), rand_digit(), rand_digit()}, 1'(c),
              {rand_digit(), rand_digit()}, 1'(c));
      end
    end

    drive(4'h9, 1'b1, 12'h099, 1'b1, 8'h99, 1'b1);
    drive(4'h9, 1'b0, 12'h999, 1'b1, 8'h99, 1'b0);
    drive(4'h0, 1'b1, 12'h999, 1'b0, 8'h09, 1'b1);

    for (int k = 0; k < 120; k++) begin
      r3 = {rand_digit(), rand_digit(), rand_digit()};
      drive(rand_digit(), 1'($urandom_range(0, 1)), r3, 1'($urandom_range(0, 1)),
            {rand_digit(), rand_digit()}, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(posedge clock);

    // Counter use: the bench registers s back into x each clock with cin held high.
    for (int k = 0; k < 20; k++) begin
      @(posedge clock);
      fb = s1;
      #1;
      x1   = (k == 0) ? 4'h0 : fb;
      cin1 = 1'b1;
      ce.x = {8'h0, x1}; ce.ci = 1'b1; ce.e = 1'b0; ce.stamp = cyc;
      ce.s = 12'((k % 10 + 1) % 10);
      ce.co = ((k % 10) == 9);
      q1.push_back(ce);
    end
    repeat (3) @(posedge clock);

    drive(4'h9, 1'b1, 12'h999, 1'b1, 8'h05, 1'b1);
    drive(4'h9, 1'b1, 12'h999, 1'b1, 8'hA3, 1'b1);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_ = 1'b0;
    #1;
    check("reg_async_reset", {4'h0, xr}, cinr, {4'h0, sr}, coutr, errr, 12'h0, 1'b0, 1'b0);
    check("comb_ignores_reset", {8'h0, x1}, cin1, {8'h0, s1}, cout1, err1, 12'h0, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    check("reg_held_in_reset", {4'h0, xr}, cinr, {4'h0, sr}, coutr, errr, 12'h0, 1'b0, 1'b0);
    check("comb_in_reset", {8'h0, x1}, cin1, {8'h0, s1}, cout1, err1, 12'h0, 1'b1, 1'b0);
    #3;
    reset_ = 1'b1;
    #1;
    check("reg_no_capture_yet", {4'h0, xr}, cinr, {4'h0, sr}, coutr, errr, 12'h0, 1'b0, 1'b0);
    check("comb_after_reset", {8'h0, x1}, cin1, {8'h0, s1}, cout1, err1, 12'h0, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    check("reg_first_capture", {4'h0, xr}, cinr, {4'h0, sr}, coutr, errr, 12'h0A4, 1'b0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      drive(rand_digit(), 1'($urandom_range(0, 1)), {rand_digit(), rand_digit(), rand_digit()},
            1'($urandom_range(0, 1)), {rand_digit(), rand_digit()}, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(posedge clock);

    n_vec++;
    if (q1.size() + q3.size() + qr.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending results, required 0", q1.size() + q3.size() + qr.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
